// File: rtl/mapper_frame_ctrl.sv
// ---------------------------------------------------------------------------
// mapper_frame_ctrl
//
// Frame-level scheduler for the OFDM mapper. It starts and stops the mapper,
// counts symbols within a frame, and drives the mapper's enable/ready_frame
// and active configuration (M, bw, ss). Host configuration goes into a shadow
// copy and is moved into the active copy only at start or at a frame
// boundary, so every frame is mapped with a single consistent setting. The
// payload grant (ready_frame) is decided once per frame from the upstream
// buffer fill level.
//
// Optional feature macro: MAPPER_FRAME_CTRL_UNDERRUN_EN
//   When defined, adds underrun_cnt, a saturating count of frame boundaries
//   whose grant evaluated to 0. It is cleared by rst and by start.
//
// Ports:
//   clk          symbol clock
//   rst          synchronous active-high reset
//   start        pulse, begin transmission (ignored while busy)
//   stop         pulse, stop at the next frame boundary (ignored in IDLE)
//   cfg_we       strobe, write cfg_M/cfg_bw/cfg_ss into the shadow config
//   cfg_M        modulation index, legal 1..6
//   cfg_bw       bandwidth/map index, legal 0..5
//   cfg_ss       spreading factor, legal 1..15
//   buf_level    payload bits available upstream
//   map_oeop     mapper end-of-symbol pulse
//   enable       mapper enable
//   ready_frame  payload granted for the current frame
//   index_M/bw/ss active configuration
//   busy         controller not idle
//   sym_cnt      symbol index within the frame
//   frame_cnt    frames completed since start (wraps)
//   cfg_err      one-cycle pulse after an illegal cfg_we write
//   underrun_cnt (optional) saturating count of ungranted frames
// ---------------------------------------------------------------------------
module mapper_frame_ctrl #(
   parameter int FRAME_SYMS     = 50,
   parameter int N_PREAMB       = 2,
   parameter int LEVEL_W        = 16,
   parameter int FRAME_BITS_THR = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               cfg_we,
   input  logic [2:0]         cfg_M,
   input  logic [2:0]         cfg_bw,
   input  logic [3:0]         cfg_ss,
   input  logic [LEVEL_W-1:0] buf_level,
   input  logic               map_oeop,
   output logic               enable,
   output logic               ready_frame,
   output logic [2:0]         index_M,
   output logic [2:0]         index_bw,
   output logic [3:0]         index_ss,
   output logic               busy,
   output logic [5:0]         sym_cnt,
   output logic [15:0]        frame_cnt,
   output logic               cfg_err
`ifdef MAPPER_FRAME_CTRL_UNDERRUN_EN
   ,
   output logic [15:0]        underrun_cnt
`endif
);

   // A frame always carries its preamble plus at least one data symbol; a
   // misconfigured FRAME_SYMS is stretched rather than producing a frame
   // that ends inside the preamble.
   localparam int FRAME_SYMS_EFF = (FRAME_SYMS > N_PREAMB) ? FRAME_SYMS : (N_PREAMB + 1);
   localparam logic [5:0] LAST_SYM = 6'(FRAME_SYMS_EFF - 1);

   // One extra bit so a threshold equal to 2**LEVEL_W never aliases to 0.
   localparam logic [LEVEL_W:0] GRANT_THR = (LEVEL_W + 1)'(FRAME_BITS_THR);

   localparam logic [2:0] RST_M  = 3'd2;
   localparam logic [2:0] RST_BW = 3'd0;
   localparam logic [3:0] RST_SS = 4'd1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [5:0]  sym_cnt_reg, sym_cnt_next;
   logic [15:0] frame_cnt_reg, frame_cnt_next;
   logic        enable_reg, enable_next;
   logic        ready_reg, ready_next;
   logic        cfg_err_reg, cfg_err_next;
   logic        pend_reg, pend_next;
   logic        stop_pend_reg, stop_pend_next;

   logic [2:0]  act_m_reg, act_m_next;
   logic [2:0]  act_bw_reg, act_bw_next;
   logic [3:0]  act_ss_reg, act_ss_next;
   logic [2:0]  shd_m_reg, shd_m_next;
   logic [2:0]  shd_bw_reg, shd_bw_next;
   logic [3:0]  shd_ss_reg, shd_ss_next;

`ifdef MAPPER_FRAME_CTRL_UNDERRUN_EN
   logic [15:0] underrun_reg, underrun_next;
`endif

   logic cfg_legal;
   logic grant;
   logic boundary;
   logic apply;

   // ---------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------
   always_comb begin
      cfg_legal = cfg_we && (cfg_M >= 3'd1) && (cfg_M <= 3'd6) &&
                  (cfg_bw <= 3'd5) && (cfg_ss != 4'd0);
      grant     = ({1'b0, buf_level} >= GRANT_THR);
      boundary  = (state_reg == ST_RUN) && map_oeop && (sym_cnt_reg == LAST_SYM);
      apply     = 1'b0;

      state_next     = state_reg;
      sym_cnt_next   = sym_cnt_reg;
      frame_cnt_next = frame_cnt_reg;
      enable_next    = enable_reg;
      ready_next     = ready_reg;
      cfg_err_next   = cfg_we && !cfg_legal;
      pend_next      = pend_reg;
      stop_pend_next = stop_pend_reg;
      act_m_next     = act_m_reg;
      act_bw_next    = act_bw_reg;
      act_ss_next    = act_ss_reg;
      shd_m_next     = shd_m_reg;
      shd_bw_next    = shd_bw_reg;
      shd_ss_next    = shd_ss_reg;
`ifdef MAPPER_FRAME_CTRL_UNDERRUN_EN
      underrun_next  = underrun_reg;
`endif

      case (state_reg)
         ST_IDLE: begin
            enable_next = 1'b0;
            if (start) begin
               apply          = 1'b1;
               sym_cnt_next   = 6'd0;
               frame_cnt_next = 16'd0;
`ifdef MAPPER_FRAME_CTRL_UNDERRUN_EN
               underrun_next  = 16'd0;
`endif
               state_next     = ST_ARM;
            end
         end

         ST_ARM: begin
            enable_next = 1'b1;
            ready_next  = grant;
            state_next  = ST_RUN;
            if (stop) begin
               stop_pend_next = 1'b1;
            end
         end

         ST_RUN: begin
            if (boundary) begin
               sym_cnt_next   = 6'd0;
               frame_cnt_next = frame_cnt_reg + 16'd1;
               ready_next     = grant;
               if (pend_reg) begin
                  apply = 1'b1;
               end
`ifdef MAPPER_FRAME_CTRL_UNDERRUN_EN
               if (!grant && (underrun_reg != 16'hFFFF)) begin
                  underrun_next = underrun_reg + 16'd1;
               end
`endif
               if (stop_pend_reg) begin
                  enable_next    = 1'b0;
                  stop_pend_next = 1'b0;
                  state_next     = ST_IDLE;
               end
            end else if (map_oeop) begin
               sym_cnt_next = sym_cnt_reg + 6'd1;
            end
            // A stop arriving on the boundary that already honours an
            // earlier stop is dropped: the controller is heading to IDLE.
            if (stop && !(boundary && stop_pend_reg)) begin
               stop_pend_next = 1'b1;
            end
         end

         default: begin
            enable_next = 1'b0;
            state_next  = ST_IDLE;
         end
      endcase

      // The apply reads the shadow as it was before this cycle's write, so
      // a write coinciding with start/boundary waits for the next frame.
      if (apply) begin
         act_m_next  = shd_m_reg;
         act_bw_next = shd_bw_reg;
         act_ss_next = shd_ss_reg;
         pend_next   = 1'b0;
      end
      if (cfg_legal) begin
         shd_m_next  = cfg_M;
         shd_bw_next = cfg_bw;
         shd_ss_next = cfg_ss;
         pend_next   = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         sym_cnt_reg   <= 6'd0;
         frame_cnt_reg <= 16'd0;
         enable_reg    <= 1'b0;
         ready_reg     <= 1'b0;
         cfg_err_reg   <= 1'b0;
         pend_reg      <= 1'b0;
         stop_pend_reg <= 1'b0;
         act_m_reg     <= RST_M;
         act_bw_reg    <= RST_BW;
         act_ss_reg    <= RST_SS;
         shd_m_reg     <= RST_M;
         shd_bw_reg    <= RST_BW;
         shd_ss_reg    <= RST_SS;
`ifdef MAPPER_FRAME_CTRL_UNDERRUN_EN
         underrun_reg  <= 16'd0;
`endif
      end else begin
         state_reg     <= state_next;
         sym_cnt_reg   <= sym_cnt_next;
         frame_cnt_reg <= frame_cnt_next;
         enable_reg    <= enable_next;
         ready_reg     <= ready_next;
         cfg_err_reg   <= cfg_err_next;
         pend_reg      <= pend_next;
         stop_pend_reg <= stop_pend_next;
         act_m_reg     <= act_m_next;
         act_bw_reg    <= act_bw_next;
         act_ss_reg    <= act_ss_next;
         shd_m_reg     <= shd_m_next;
         shd_bw_reg    <= shd_bw_next;
         shd_ss_reg    <= shd_ss_next;
`ifdef MAPPER_FRAME_CTRL_UNDERRUN_EN
         underrun_reg  <= underrun_next;
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign enable      = enable_reg;
   assign ready_frame = ready_reg;
   assign index_M     = act_m_reg;
   assign index_bw    = act_bw_reg;
   assign index_ss    = act_ss_reg;
   assign busy        = (state_reg != ST_IDLE);
   assign sym_cnt     = sym_cnt_reg;
   assign frame_cnt   = frame_cnt_reg;
   assign cfg_err     = cfg_err_reg;
`ifdef MAPPER_FRAME_CTRL_UNDERRUN_EN
   assign underrun_cnt = underrun_reg;
`endif

endmodule

// File: tb/tb_mapper_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mapper_frame_ctrl
//
// Directed steps plus a randomized phase, all checked every cycle against a
// behavioural model of the frame scheduler (running/arming flags, symbol and
// frame counters, active and shadow configuration as plain integers).
// ---------------------------------------------------------------------------
module tb_mapper_frame_ctrl;

   localparam int FRAME_SYMS = 50;
   localparam int THR        = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_M = 3'd0;
   logic [2:0]  cfg_bw = 3'd0;
   logic [3:0]  cfg_ss = 4'd0;
   logic [15:0] buf_level = 16'd0;
   logic        map_oeop = 1'b0;

   logic        enable;
   logic        ready_frame;
   logic [2:0]  index_M;
   logic [2:0]  index_bw;
   logic [3:0]  index_ss;
   logic        busy;
   logic [5:0]  sym_cnt;
   logic [15:0] frame_cnt;
   logic        cfg_err;
`ifdef MAPPER_FRAME_CTRL_UNDERRUN_EN
   logic [15:0] underrun_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   mapper_frame_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .cfg_we      (cfg_we),
      .cfg_M       (cfg_M),
      .cfg_bw      (cfg_bw),
      .cfg_ss      (cfg_ss),
      .buf_level   (buf_level),
      .map_oeop    (map_oeop),
      .enable      (enable),
      .ready_frame (ready_frame),
      .index_M     (index_M),
      .index_bw    (index_bw),
      .index_ss    (index_ss),
      .busy        (busy),
      .sym_cnt     (sym_cnt),
      .frame_cnt   (frame_cnt),
      .cfg_err     (cfg_err)
`ifdef MAPPER_FRAME_CTRL_UNDERRUN_EN
      ,
      .underrun_cnt(underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: observed no end of test, expected $finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- behavioural model ----------------
   bit m_busy, m_arming, m_ready, m_err, m_pend, m_stop;
   int m_sym, m_frames, m_under;
   int a_M, a_bw, a_ss, s_M, s_bw, s_ss;

   task automatic model_reset();
      m_busy = 0; m_arming = 0; m_ready = 0; m_err = 0; m_pend = 0; m_stop = 0;
      m_sym = 0; m_frames = 0; m_under = 0;
      a_M = 2; a_bw = 0; a_ss = 1; s_M = 2; s_bw = 0; s_ss = 1;
   endtask

   task automatic model_step(input bit r, input bit s, input bit sp, input bit we,
                             input int M, input int bw, input int ss,
                             input int lvl, input bit oe);
      bit legal, g;
      if (r) begin
         model_reset();
         return;
      end
      legal = we && M >= 1 && M <= 6 && bw <= 5 && ss != 0;
      g     = (lvl >= THR);
      m_err = we && !legal;
      if (!m_busy) begin
         if (s) begin
            a_M = s_M; a_bw = s_bw; a_ss = s_ss; m_pend = 0;
            m_sym = 0; m_frames = 0; m_under = 0;
            m_busy = 1; m_arming = 1;
         end
      end else if (m_arming) begin
         m_arming = 0;
         m_ready  = g;
         if (sp) m_stop = 1;
      end else if (oe && m_sym == FRAME_SYMS - 1) begin
         m_sym    = 0;
         m_frames = (m_frames + 1) % 65536;
         if (m_pend) begin
            a_M = s_M; a_bw = s_bw; a_ss = s_ss; m_pend = 0;
         end
         m_ready = g;
         if (!g && m_under < 65535) m_under++;
         $display("frame %0d done: grant=%0b cfg=%0d/%0d/%0d stop=%0b",
                  m_frames, g, a_M, a_bw, a_ss, m_stop);
         if (m_stop) begin
            m_stop = 0; m_busy = 0;
         end else if (sp) begin
            m_stop = 1;
         end
      end else begin
         if (oe) m_sym++;
         if (sp) m_stop = 1;
      end
      if (legal) begin
         s_M = M; s_bw = bw; s_ss = ss; m_pend = 1;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("enable",      32'(enable),      32'(m_busy && !m_arming));
      chk("ready_frame", 32'(ready_frame), 32'(m_ready));
      chk("index_M",     32'(index_M),     32'(a_M));
      chk("index_bw",    32'(index_bw),    32'(a_bw));
      chk("index_ss",    32'(index_ss),    32'(a_ss));
      chk("busy",        32'(busy),        32'(m_busy));
      chk("sym_cnt",     32'(sym_cnt),     32'(m_sym));
      chk("frame_cnt",   32'(frame_cnt),   32'(m_frames));
      chk("cfg_err",     32'(cfg_err),     32'(m_err));
`ifdef MAPPER_FRAME_CTRL_UNDERRUN_EN
      chk("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
`endif
   endtask

   // One clock: sample the driven inputs into the model, check #1 after the
   // edge, then drop all pulse inputs.
   task automatic tick();
      bit c_rst, c_start, c_stop, c_we, c_oe;
      int c_M, c_bw, c_ss, c_lvl;
      c_rst = rst; c_start = start; c_stop = stop; c_we = cfg_we; c_oe = map_oeop;
      c_M = int'(cfg_M); c_bw = int'(cfg_bw); c_ss = int'(cfg_ss); c_lvl = int'(buf_level);
      @(posedge clk);
      model_step(c_rst, c_start, c_stop, c_we, c_M, c_bw, c_ss, c_lvl, c_oe);
      #1;
      check_all();
      rst = 0; start = 0; stop = 0; cfg_we = 0; map_oeop = 0;
   endtask

   task automatic run_until_sym(input int target);
      int guard = 0;
      while (!(m_busy && !m_arming && m_sym == target) && guard < 500) begin
         map_oeop = 1;
         tick();
         guard++;
      end
      if (guard >= 500) chk("run_until_sym_timeout", 32'd1, 32'd0);
   endtask

   task automatic write_cfg(input int M, input int bw, input int ss);
      cfg_we = 1;
      cfg_M  = 3'(M);
      cfg_bw = 3'(bw);
      cfg_ss = 4'(ss);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_reset();

      $display("step: reset");
      rst = 1; tick();
      rst = 1; tick();
      rst = 1; tick();
      chk("rst_enable", 32'(enable), 32'd0);
      chk("rst_M", 32'(index_M), 32'd2);
      chk("rst_ss", 32'(index_ss), 32'd1);

      $display("step: illegal config writes");
      write_cfg(7, 0, 1); tick();
      chk("err_M7", 32'(cfg_err), 32'd1);
      tick();
      chk("err_pulse_end", 32'(cfg_err), 32'd0);
      write_cfg(2, 0, 0); tick();
      chk("err_ss0", 32'(cfg_err), 32'd1);

      $display("step: start with buf_level 5000");
      buf_level = 16'd5000;
      start = 1; tick();
      chk("arm_enable", 32'(enable), 32'd0);
      tick();
      chk("start_enable", 32'(enable), 32'd1);
      chk("start_ready", 32'(ready_frame), 32'd1);
      chk("start_M", 32'(index_M), 32'd2);
      chk("start_ss", 32'(index_ss), 32'd1);

      $display("step: config write mid-frame, starved boundary");
      run_until_sym(10);
      write_cfg(4, 3, 2); tick();
      chk("midframe_M_held", 32'(index_M), 32'd2);
      run_until_sym(49);
      buf_level = 16'd100;
      map_oeop = 1; tick();
      chk("bnd_sym", 32'(sym_cnt), 32'd0);
      chk("bnd_frame", 32'(frame_cnt), 32'd1);
      chk("bnd_ready", 32'(ready_frame), 32'd0);
      chk("bnd_M", 32'(index_M), 32'd4);
      chk("bnd_bw", 32'(index_bw), 32'd3);
      chk("bnd_ss", 32'(index_ss), 32'd2);

      $display("step: stop mid-frame");
      buf_level = 16'(THR);
      run_until_sym(20);
      stop = 1; tick();
      run_until_sym(49);
      chk("stop_enable_held", 32'(enable), 32'd1);
      map_oeop = 1; tick();
      chk("stop_enable", 32'(enable), 32'd0);
      chk("stop_busy", 32'(busy), 32'd0);
      stop = 1; tick();
      tick();
      chk("idle_stop_busy", 32'(busy), 32'd0);

      $display("step: cfg_we and stop on the boundary cycle");
      buf_level = 16'd5000;
      start = 1; tick();
      tick();
      run_until_sym(5);
      write_cfg(6, 5, 15); tick();
      run_until_sym(49);
      write_cfg(1, 0, 3); stop = 1; map_oeop = 1; tick();
      chk("sim_M_old_shadow", 32'(index_M), 32'd6);
      chk("sim_ss_old_shadow", 32'(index_ss), 32'd15);
      chk("sim_still_enabled", 32'(enable), 32'd1);
      run_until_sym(49);
      map_oeop = 1; tick();
      chk("sim_M_new", 32'(index_M), 32'd1);
      chk("sim_stopped", 32'(enable), 32'd0);

      $display("step: reset mid-frame");
      start = 1; tick();
      tick();
      run_until_sym(30);
      rst = 1; tick();
      chk("midrst_enable", 32'(enable), 32'd0);
      chk("midrst_sym", 32'(sym_cnt), 32'd0);
      chk("midrst_M", 32'(index_M), 32'd2);
      chk("midrst_ss", 32'(index_ss), 32'd1);

      $display("step: randomized traffic");
      for (int c = 0; c < 4000; c++) begin
         map_oeop = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 3))
            0: buf_level = 16'(THR);
            1: buf_level = 16'(THR - 1);
            2: buf_level = 16'($urandom_range(0, THR - 1));
            default: buf_level = 16'($urandom_range(THR, 65535));
         endcase
         if ($urandom_range(0, 39) == 0)
            write_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 15)));
         if ($urandom_range(0, 399) == 0) stop = 1;
         if ($urandom_range(0, 19) == 0) start = 1;
         if ($urandom_range(0, 2999) == 0) rst = 1;
         tick();
      end

`ifdef MAPPER_FRAME_CTRL_UNDERRUN_EN
      $display("step: underrun over three starved frames");
      rst = 1; tick();
      buf_level = 16'd0;
      start = 1; tick();
      tick();
      for (int f = 0; f < 3; f++) begin
         run_until_sym(49);
         map_oeop = 1; tick();
      end
      chk("underrun_3", 32'(underrun_cnt), 32'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mapper_frame_ctrl.md
Name: mapper_frame_ctrl

Overview:
- Frame-level scheduler that sequences the OFDM mapper: starts and stops it, and owns its `enable`, `ready_frame`, `index_M_in`, `index_bw` and `index_ss` inputs.
- Double-buffers host configuration and applies it only at frame boundaries, so a frame is never mapped with mixed settings.
- Gates data-frame requests against the upstream payload buffer fill level.
- Sits between the host/CSR side and the mapper, in the mapper's symbol clock domain `clk`.

Parameters:
- FRAME_SYMS, 50, OFDM symbols per frame (preamble included).
- N_PREAMB, 2, preamble symbols at the start of each frame.
- LEVEL_W, 16, width of the buffer fill-level input.
- FRAME_BITS_THR, 4096, minimum `buf_level` needed to grant a data frame.

Ports:
- clk  in  1  symbol clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse: begin transmission
- stop  in  1  single-cycle pulse: stop at the next frame boundary
- cfg_we  in  1  strobe that writes the shadow configuration
- cfg_M  in  3  modulation index, legal 1..6
- cfg_bw  in  3  bandwidth/map index, legal 0..5
- cfg_ss  in  4  spreading factor, legal 1..15
- buf_level  in  LEVEL_W  payload bits available upstream
- map_oeop  in  1  mapper end-of-symbol pulse
- enable  out  1  mapper enable
- ready_frame  out  1  payload granted for the current frame
- index_M  out  3  active M
- index_bw  out  3  active bw
- index_ss  out  4  active ss
- busy  out  1  state != IDLE
- sym_cnt  out  6  symbol index within the frame
- frame_cnt  out  16  frames completed since start, wraps
- cfg_err  out  1  one-cycle pulse on an illegal `cfg_we` write

Behaviour:
- Reset values:
  - `enable`, `ready_frame`, `busy`, `cfg_err` = 0.
  - `sym_cnt`, `frame_cnt` = 0.
  - Active and shadow config = M 2, bw 0, ss 1.
  - `pend` = 0, `stop_pend` = 0; state = IDLE.
  - Reset mid-frame: everything returns to these values on the next edge; the mapper sees `enable` = 0.
- Config write:
  - On `cfg_w`e, if `cfg_M` ∈ 1..6, `cfg_bw` ≤ 5 and `cfg_ss` ≠ 0: shadow ← inputs, `pend` ← 1.
  - Otherwise: shadow unchanged and `cfg_err` = 1 on the next cycle.
- States:
  - IDLE: `enable` = 0. On `start`: active ← shadow, `pend` ← 0, `sym_cnt` ← 0, go to ARM.
  - ARM: one cycle. `enable` ← 1, evaluate the grant, go to RUN.
  - RUN: `enable` = 1. Each `map_oeop` increments `sym_cnt`.
  - Frame boundary: `map_oeop` while `sym_cnt` = FRAME_SYMS−1. Then:
    - `sym_cnt` ← 0 and `frame_cnt` ← `frame_cnt`+1.
    - If `pend`: active ← shadow, `pend` ← 0.
    - Re-evaluate the grant.
    - If `stop_pend`: `enable` ← 0, `stop_pend` ← 0, go to IDLE.
- Stop:
  - `stop` in ARM or RUN sets `stop_pend`.
  - `stop` in IDLE is ignored.
  - `start` while `busy` is ignored.
- Grant: `ready_frame` ← (`buf_level` ≥ FRAME_BITS_THR), registered at ARM and at each frame boundary, then held constant for the whole frame.
- Simultaneous events:
  - `cfg_we` on the boundary cycle: boundary apply uses the old shadow; the new write sets `pend` for the next frame.
  - `stop` on the boundary cycle: takes effect at the following boundary.
- `index_*` outputs are registered from the active config. They change only at `start` or a frame boundary, so they are stable one cycle before the mapper's next symbol 0.
- Latency: `start` → `enable` high = 2 cycles.

Optional Feature:
- Macro: MAPPER_FRAME_CTRL_UNDERRUN_EN.
- Defined: adds port `underrun_cnt` (out, 16).
  - Increments, saturating at 0xFFFF, at each boundary in RUN where the grant evaluates to 0.
  - Cleared by `rst` and by `start`.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then `start` with `buf_level` = 5000 → `enable` = 1 two cycles later, `ready_frame` = 1, `index_M` = 2, `index_ss` = 1.
- RUN, 50 `map_oeop` pulses → `sym_cnt` wraps 49→0 and `frame_cnt` = 1; `buf_level` = 100 at the boundary → `ready_frame` = 0 for the next frame.
- `cfg_we` M = 4, bw = 3, ss = 2 at `sym_cnt` = 10 → `index_*` unchanged until the boundary, then 4/3/2.
- `cfg_we` with M = 7, or with ss = 0 → `cfg_err` pulses for one cycle; shadow and active unchanged.
- `stop` at `sym_cnt` = 20 → `enable` stays 1 until the 50th `map_oeop`, then 0, `busy` = 0; a second `stop` in IDLE has no effect.
- `rst` asserted at `sym_cnt` = 30 → next cycle `enable` = 0, `sym_cnt` = 0, config back to defaults. With MAPPER_FRAME_CTRL_UNDERRUN_EN defined and `buf_level` = 0 for 3 frames → `underrun_cnt` = 3.
